// File: rtl/serial_sub4.sv
// Bit-serial subtractor: D = A - B - Bi over WIDTH cycles, LSB first,
// using one full-subtractor cell and a borrow flop behind a Start/Busy/Done handshake.
module serial_sub4 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bi,
    output logic [WIDTH-1:0] D,
    output logic             Bo,
    output logic             Z,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             load;
    logic             step;
    logic             finish;
    logic             busy_nxt;
    logic             done_nxt;
    logic             d_bit;
    logic             br_nxt;
    logic [WIDTH-1:0] res_shift;

    // Full-subtractor cell on the current LSBs
    always_comb begin
        d_bit     = ra[0] ^ rb[0] ^ br;
        br_nxt    = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
        res_shift = {d_bit, res[WIDTH-1:1]};
    end

    // Next-state and control decode
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    load      = 1'b1;
                    busy_nxt  = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                step     = 1'b1;
                busy_nxt = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    finish    = 1'b1;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and handshake registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            state <= state_nxt;
            Busy  <= busy_nxt;
            Done  <= done_nxt;
        end
    end

    // Operand shifters, borrow, counter and result; outputs change only on completion
    always_ff @(posedge CLK) begin
        if (RST) begin
            ra  <= '0;
            rb  <= '0;
            br  <= 1'b0;
            res <= '0;
            cnt <= '0;
            D   <= '0;
            Bo  <= 1'b0;
            Z   <= 1'b0;
        end else begin
            if (load) begin
                ra  <= A;
                rb  <= B;
                br  <= Bi;
                res <= '0;
                cnt <= '0;
            end else if (step) begin
                ra  <= {1'b0, ra[WIDTH-1:1]};
                rb  <= {1'b0, rb[WIDTH-1:1]};
                br  <= br_nxt;
                res <= res_shift;
                cnt <= cnt + CW'(1);
            end
            if (finish) begin
                D  <= res_shift;
                Bo <= br_nxt;
                Z  <= (res_shift == '0);
            end
        end
    end

endmodule

// File: tb/tb_serial_sub4.sv
// Directed self-checking bench for serial_sub4 (WIDTH=4).
module tb_serial_sub4;

    logic       CLK = 1'b0;
    logic       RST;
    logic       Start;
    logic [3:0] A;
    logic [3:0] B;
    logic       Bi;
    logic [3:0] D;
    logic       Bo;
    logic       Z;
    logic       Busy;
    logic       Done;

    int checks   = 0;
    int failures = 0;

    serial_sub4 #(.WIDTH(4)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Bi    (Bi),
        .D     (D),
        .Bo    (Bo),
        .Z     (Z),
        .Busy  (Busy),
        .Done  (Done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One-cycle Start, operands scrambled during SHIFT, then result check
    task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b, input logic bi,
                         input logic [3:0] exp_d, input logic exp_bo, input logic exp_z,
                         input logic [3:0] prev_d);
        int n;
        A = a; B = b; Bi = bi; Start = 1'b1;
        tick();
        Start = 1'b0;
        check({tag, "_busy"}, 32'(Busy), 32'd1);
        check({tag, "_hold"}, 32'(D), 32'(prev_d));
        n = 0;
        while (!Done && n < 20) begin
            A  = 4'($urandom);
            B  = 4'($urandom);
            Bi = 1'($urandom);
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd4);
        check({tag, "_d"},   32'(D),  32'(exp_d));
        check({tag, "_bo"},  32'(Bo), 32'(exp_bo));
        check({tag, "_z"},   32'(Z),  32'(exp_z));
        check({tag, "_bsy0"}, 32'(Busy), 32'd0);
        tick();
        check({tag, "_done1"}, 32'(Done), 32'd0);
    endtask

    initial begin
        int dones;
        int busy_cycles;
        int next_k;
        int n;

        RST = 1'b1; Start = 1'b0; A = '0; B = '0; Bi = 1'b0;
        tick();
        tick();
        check("rst_d",    32'(D),    32'd0);
        check("rst_bo",   32'(Bo),   32'd0);
        check("rst_z",    32'(Z),    32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        RST = 1'b0;
        tick();

        do_op("s7m3", 4'd7, 4'd3, 1'b0, 4'd4, 1'b0, 1'b0, 4'd0);
        tick(); tick(); tick();
        check("s7m3_keep_d",  32'(D),  32'd4);
        check("s7m3_keep_bo", 32'(Bo), 32'd0);

        do_op("s3m7",  4'd3, 4'd7,  1'b0, 4'd12, 1'b1, 1'b0, 4'd4);
        do_op("s0m0b", 4'd0, 4'd0,  1'b1, 4'd15, 1'b1, 1'b0, 4'd12);
        do_op("s5m5",  4'd5, 4'd5,  1'b0, 4'd0,  1'b0, 1'b1, 4'd15);
        do_op("s0m15b",4'd0, 4'd15, 1'b1, 4'd0,  1'b1, 1'b1, 4'd0);
        do_op("s5m4b", 4'd5, 4'd4,  1'b1, 4'd0,  1'b0, 1'b1, 4'd0);
        do_op("s15m0", 4'd15,4'd0,  1'b0, 4'd15, 1'b0, 1'b0, 4'd0);

        // Start re-pulsed during SHIFT and DONE must be ignored
        A = 4'd9; B = 4'd2; Bi = 1'b0; Start = 1'b1;
        tick();
        Start = 1'b0;
        dones = 0;
        busy_cycles = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 2) begin
                A = 4'd1; B = 4'd1; Start = 1'b1;
            end else if (Done) begin
                Start = 1'b1;
            end else begin
                Start = 1'b0;
            end
            if (Busy) busy_cycles++;
            tick();
            if (Done) dones++;
        end
        Start = 1'b0;
        check("repulse_dones", 32'(dones), 32'd1);
        check("repulse_busy",  32'(busy_cycles), 32'd4);
        check("repulse_d",     32'(D),  32'd7);
        check("repulse_bo",    32'(Bo), 32'd0);
        check("repulse_idle",  32'(Busy), 32'd0);

        // Reset on the second SHIFT cycle discards the operation
        A = 4'd9; B = 4'd2; Bi = 1'b0; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("midrst_d",    32'(D),    32'd0);
        check("midrst_bo",   32'(Bo),   32'd0);
        check("midrst_z",    32'(Z),    32'd0);
        check("midrst_busy", 32'(Busy), 32'd0);
        check("midrst_done", 32'(Done), 32'd0);
        tick();
        do_op("s6m1", 4'd6, 4'd1, 1'b0, 4'd5, 1'b0, 1'b0, 4'd0);

        // Start held high: one result every WIDTH+2 cycles
        A = 4'd8; B = 4'd1; Bi = 1'b0; Start = 1'b1;
        tick();
        dones = 0;
        next_k = 4;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (Done) begin
                dones++;
                check("held_period", 32'(k), 32'(next_k));
                check("held_d",  32'(D),  32'd7);
                check("held_bo", 32'(Bo), 32'd0);
                next_k += 6;
            end
        end
        check("held_dones", 32'(dones), 32'd3);
        Start = 1'b0;
        n = 0;
        while (!Done && n < 20) begin
            tick();
            n++;
        end
        check("held_drain", 32'(n < 20), 32'd1);
        tick();
        check("final_idle", 32'(Busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
